// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the program counter and sequences instruction fetch for the CPU core.
//   The FSM runs IDLE -> FETCH -> EXEC, with a HALT state. It uses a req/ack
//   handshake to instruction memory. The next PC comes from one of three sources:
//   increment, redirect (branch/jump) or, optionally, a return stack.
//
// Configuration macro
//   PC_SEQ_RAS_EN  when defined, adds a RAS_DEPTH-entry circular return
//                  stack that is driven by Call_Valid / Ret_Valid. When it is
//                  undefined, those two ports are ignored and Ras_Err reads 0.
//
// Ports
//   Clk, Clear              clock / asynchronous active-high reset
//   Fetch_Req, Fetch_Addr   fetch request (high in FETCH) and its address (=PC)
//   Fetch_Ack               memory done, only looked at in FETCH
//   Instr_Valid             high in every EXEC cycle
//   Stall, Halt             EXEC controls: hold the instruction / go to HALT
//   Redirect_Valid/_Target  branch/jump target; also the call target
//   Resume                  leave HALT
//   Call_Valid, Ret_Valid   push PC+1 and jump / pop into PC (RAS build only)
//   PC, Next_PC             current PC and PC+1 (mod 2^PC_W)
//   Halted                  high in HALT
//   Ras_Err                 sticky return-stack underflow/overflow
module pc_sequencer #(
  parameter int              PC_W      = 8,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            Clk,
  input  logic            Clear,
  output logic            Fetch_Req,
  output logic [PC_W-1:0] Fetch_Addr,
  input  logic            Fetch_Ack,
  output logic            Instr_Valid,
  input  logic            Stall,
  input  logic            Redirect_Valid,
  input  logic [PC_W-1:0] Redirect_Target,
  input  logic            Halt,
  input  logic            Resume,
  input  logic            Call_Valid,
  input  logic            Ret_Valid,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] Next_PC,
  output logic            Halted,
  output logic            Ras_Err
);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_EXEC, ST_HALT} state_t;

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_plus1;

  // Wraps silently at 2^PC_W.
  assign pc_plus1 = pc_q + PC_ONE;

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

  logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0] top_q;      // next slot to write; top_q-1 holds the newest entry
  logic [PTR_W-1:0] top_m1;
  logic [PTR_W:0]   cnt_q;      // live entries, saturates at RAS_DEPTH
  logic             ras_err_q;
  logic             do_push;

  assign top_m1  = top_q - PTR_ONE;
  // Same priority as the FSM: Halt, Stall and Ret all beat a call.
  assign do_push = (state_q == ST_EXEC) && !Halt && !Stall && !Ret_Valid && Call_Valid;

  // When the stack is full, top_q already points at the oldest entry, so a push overwrites it.
  always_ff @(posedge Clk) begin
    if (do_push) ras_mem[top_q] <= pc_plus1;
  end

  assign Ras_Err = ras_err_q;
`else
  logic unused_ras_ports;
  localparam int unused_ras_depth = RAS_DEPTH;
  assign unused_ras_ports = Call_Valid ^ Ret_Valid;
  assign Ras_Err          = 1'b0;
`endif

  always_ff @(posedge Clk or posedge Clear) begin
    if (Clear) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
`ifdef PC_SEQ_RAS_EN
      top_q     <= '0;
      cnt_q     <= '0;
      ras_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: state_q <= ST_FETCH;
        ST_FETCH: begin
          if (Fetch_Ack) state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          // Each edge performs exactly one action, and the highest priority wins.
          if (Halt) begin
            pc_q    <= pc_plus1;
            state_q <= ST_HALT;
          end else if (Stall) begin
            state_q <= ST_EXEC;
`ifdef PC_SEQ_RAS_EN
          end else if (Ret_Valid) begin
            if (cnt_q == '0) begin
              pc_q      <= pc_plus1;
              ras_err_q <= 1'b1;
            end else begin
              pc_q  <= ras_mem[top_m1];
              top_q <= top_m1;
              cnt_q <= cnt_q - CNT_ONE;
            end
            state_q <= ST_FETCH;
          end else if (Call_Valid) begin
            top_q <= top_q + PTR_ONE;
            if (cnt_q == CNT_MAX) ras_err_q <= 1'b1;
            else                  cnt_q     <= cnt_q + CNT_ONE;
            pc_q    <= Redirect_Target;
            state_q <= ST_FETCH;
`endif
          end else if (Redirect_Valid) begin
            pc_q    <= Redirect_Target;
            state_q <= ST_FETCH;
          end else begin
            pc_q    <= pc_plus1;
            state_q <= ST_FETCH;
          end
        end
        ST_HALT: begin
          if (Resume) state_q <= ST_FETCH;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign Fetch_Req   = (state_q == ST_FETCH);
  assign Instr_Valid = (state_q == ST_EXEC);
  assign Halted      = (state_q == ST_HALT);
  assign Fetch_Addr  = pc_q;
  assign PC          = pc_q;
  assign Next_PC     = pc_plus1;

endmodule
